// File: rtl/sd_audio_streamer.sv
// sd_audio_streamer
//   Pulls 512-byte blocks from an SD block reader, packs byte pairs into
//   little-endian 16-bit PCM samples, buffers them in a FIFO and plays one
//   sample per CLK_DIV clocks.
//
// Ports
//   clk, rst_n      system clock (rising edge), async active-low reset
//   enable          streaming enable (level); a rising edge starts a session
//   start_block     first SD block address, captured on the enable rise
//   sd_card_ready   reader idle, may accept a block request
//   data_in/idx/rdy byte stream from the reader (idx 0..511 within a block)
//   read_block      one-cycle block request, block_addr holds the address
//   sample_out      current PCM sample, updated with sample_strobe
//   sample_strobe   one-cycle pulse per sample period
//   fifo_level      samples buffered
//   underrun        sticky: FIFO was empty at a sample tick
module sd_audio_streamer #(
    parameter int CLK_DIV = 1134,
    parameter int FIFO_AW = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [31:0]        start_block,
    input  logic               sd_card_ready,
    input  logic [7:0]         data_in,
    input  logic [11:0]        data_idx,
    input  logic               data_rdy,
    output logic               read_block,
    output logic [31:0]        block_addr,
    output logic [15:0]        sample_out,
    output logic               sample_strobe,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               underrun
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [FIFO_AW:0] FULL_LVL = {1'b1, {FIFO_AW{1'b0}}};
    // One block yields 256 samples; only request when they all fit.
    localparam logic [31:0] BLK_SAMPLES = 32'd256;

    typedef enum logic [1:0] {IDLE, CHECK, REQ, RECV} state_t;

    state_t               state, state_nxt;
    logic                 en_q;
    logic                 en_rise;
    logic                 load_addr, inc_addr;
    logic                 byte_ok, last_byte;
    logic [FIFO_AW:0]     free_cnt;
    logic                 space_ok;

    logic [7:0]           lo_byte;
    logic                 have_lo;
    logic                 push_req, push, pop;
    logic                 full, empty;

    logic [DIV_W-1:0]     div_cnt;
    logic                 active, tick;

    logic [15:0]          mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;

    // en_q resets high so an enable held through reset is not a rise.
    assign en_rise   = enable & ~en_q;
    assign byte_ok   = data_rdy & enable & (state == RECV);
    assign last_byte = (data_idx == 12'd511);
    assign free_cnt  = FULL_LVL - fifo_level;
    assign space_ok  = (32'(free_cnt) >= BLK_SAMPLES);

    assign full     = (fifo_level == FULL_LVL);
    assign empty    = (fifo_level == '0);
    assign push_req = byte_ok & data_idx[0] & have_lo;
    assign push     = push_req & ~full;

    // Divider only runs once a session has started.
    assign active = enable & (state != IDLE);
    assign tick   = active & (div_cnt == DIV_W'(CLK_DIV - 1));
    assign pop    = tick & ~empty;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            en_q  <= 1'b1;
        end else begin
            state <= state_nxt;
            en_q  <= enable;
        end
    end

    always_comb begin
        state_nxt  = state;
        load_addr  = 1'b0;
        inc_addr   = 1'b0;
        read_block = (state == REQ);
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (en_rise) begin
                           state_nxt = CHECK;
                           load_addr = 1'b1;
                       end
                CHECK: if (sd_card_ready && space_ok) state_nxt = REQ;
                REQ:   state_nxt = RECV;
                RECV:  if (byte_ok && last_byte) begin
                           state_nxt = CHECK;
                           inc_addr  = 1'b1;
                       end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         block_addr <= '0;
        else if (load_addr) block_addr <= start_block;
        else if (inc_addr)  block_addr <= block_addr + 32'd1;
    end

    // ---------------- byte pairing ----------------
    // An odd byte only forms a sample if its even partner arrived first in
    // the same block; the latch is cleared when a new block is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_byte <= '0;
            have_lo <= 1'b0;
        end else if (!enable || state == REQ) begin
            have_lo <= 1'b0;
        end else if (byte_ok) begin
            if (!data_idx[0]) begin
                lo_byte <= data_in;
                have_lo <= 1'b1;
            end else begin
                have_lo <= 1'b0;
            end
        end
    end

    // ---------------- sample divider ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       div_cnt <= '0;
        else if (!active) div_cnt <= '0;
        else if (tick)    div_cnt <= '0;
        else              div_cnt <= div_cnt + DIV_W'(1);
    end

    // ---------------- FIFO ----------------
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {data_in, lo_byte};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (!enable) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // ---------------- sample output ----------------
    // Strobe and sample are registered together at the tick edge, the same
    // edge that pops the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_out    <= '0;
            sample_strobe <= 1'b0;
            underrun      <= 1'b0;
        end else if (!enable) begin
            sample_out    <= '0;
            sample_strobe <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            sample_strobe <= tick;
            if (tick) begin
                if (empty) begin
                    sample_out <= '0;
                    underrun   <= 1'b1;
                end else begin
                    sample_out <= mem[rd_ptr];
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_audio_streamer.sv
// Bench for sd_audio_streamer. Acts as the SD reader and keeps a queue-based
// model of buffered samples; the sample schedule is derived from the enable
// rise cycle and CLK_DIV.
module tb_sd_audio_streamer;

    localparam int CLK_DIV = 1500;
    localparam int AW      = 9;
    localparam int DEPTH   = 1 << AW;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [31:0] start_block;
    logic        sd_card_ready;
    logic [7:0]  data_in;
    logic [11:0] data_idx;
    logic        data_rdy;
    logic        read_block;
    logic [31:0] block_addr;
    logic [15:0] sample_out;
    logic        sample_strobe;
    logic [AW:0] fifo_level;
    logic        underrun;

    sd_audio_streamer #(.CLK_DIV(CLK_DIV), .FIFO_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .start_block(start_block),
        .sd_card_ready(sd_card_ready), .data_in(data_in), .data_idx(data_idx),
        .data_rdy(data_rdy), .read_block(read_block), .block_addr(block_addr),
        .sample_out(sample_out), .sample_strobe(sample_strobe),
        .fifo_level(fifo_level), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model
    logic [15:0] q[$];
    logic [7:0]  lo = '0;
    bit          have_lo = 0;
    bit          running = 0;
    bit          prev_en = 1;
    bit          blk_open = 0;
    int          rise_cyc = 0;
    int          ncyc = 0;
    int          nreq = 0;
    logic [15:0] exp_sample = '0;
    bit          exp_under = 0;
    logic [31:0] exp_addr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit tick_next();
        return running && ((ncyc + 1 - rise_cyc) % CLK_DIV == 0);
    endfunction

    // One clock: capture applied inputs, advance, then compare against model.
    task automatic cyc();
        logic a_rdy, a_en, a_recv;
        logic [11:0] a_idx;
        logic [7:0] a_din;
        int pre;
        bit tk;
        a_rdy = data_rdy; a_en = enable; a_recv = blk_open;
        a_idx = data_idx; a_din = data_in;
        @(posedge clk); #1;
        ncyc++;
        tk = 0;
        if (!a_en || !rst_n) begin
            running = 0; q.delete(); have_lo = 0; exp_under = 0; exp_sample = '0;
        end else begin
            if (!prev_en) begin
                running = 1; rise_cyc = ncyc;
            end else if (running && ((ncyc - rise_cyc) % CLK_DIV == 0)) begin
                tk = 1;
            end
            pre = q.size();
            if (tk) begin
                if (pre > 0) exp_sample = q.pop_front();
                else begin exp_sample = '0; exp_under = 1; end
            end
            if (a_rdy && a_recv) begin
                if (!a_idx[0]) begin lo = a_din; have_lo = 1; end
                else begin
                    if (have_lo && pre < DEPTH) q.push_back({a_din, lo});
                    have_lo = 0;
                end
            end
        end
        prev_en = a_en & rst_n;
        if (!rst_n) prev_en = 1;
        chk("strobe", 32'(sample_strobe), 32'(tk));
        chk("sample", 32'(sample_out), 32'(exp_sample));
        chk("level", 32'(fifo_level), 32'(q.size()));
        chk("underrun", 32'(underrun), 32'(exp_under));
        if (a_recv && a_en && !(a_rdy && a_idx == 12'd511))
            chk("addr_hold", block_addr, exp_addr);
        if (read_block) begin
            nreq++;
            chk("req_addr", block_addr, exp_addr);
            chk("req_space", 32'(q.size() <= DEPTH - 256), 32'd1);
        end
    endtask

    task automatic send_byte(input logic [11:0] idx, input logic [7:0] din);
        data_rdy = 1'b1; data_idx = idx; data_in = din;
        cyc();
        data_rdy = 1'b0;
    endtask

    task automatic start_session(input logic [31:0] sb, input logic rdy);
        enable = 1'b0; cyc(); cyc();
        start_block = sb; sd_card_ready = rdy; enable = 1'b1;
        exp_addr = sb; nreq = 0;
    endtask

    task automatic serve_block(input int gap_max, input bit fixed_first, input bit align,
                               input int extra, input int abort_at, input bit rnd_ready);
        bit found = 0;
        int pre;
        bit tk;
        logic [7:0] din;
        for (int k = 0; k < 6000 && !found; k++) begin
            if (rnd_ready) sd_card_ready = ($urandom_range(0, 3) != 0);
            cyc();
            if (read_block) found = 1;
        end
        chk("req_seen", 32'(found), 32'd1);
        if (!found) return;
        cyc();
        blk_open = 1; have_lo = 0;
        for (int i = 0; i < 512; i++) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) cyc();
            if (extra > 0 && i == 510)
                for (int e = 0; e < 2 * extra; e++) send_byte(12'(508 + e % 2), 8'($urandom));
            if (align && i == 101)
                for (int k = 0; k < CLK_DIV && !tick_next(); k++) cyc();
            din = 8'($urandom);
            if (fixed_first && i == 0) din = 8'h34;
            if (fixed_first && i == 1) din = 8'h12;
            if (i == abort_at) enable = 1'b0;
            pre = q.size();
            tk = tick_next();
            send_byte(12'(i), din);
            if (align && i == 101 && tk) chk("pushpop_level", 32'(fifo_level), 32'(pre));
            if (i == abort_at) begin
                blk_open = 0;
                chk("abort_level", 32'(fifo_level), 32'd0);
                return;
            end
        end
        blk_open = 0;
        exp_addr = exp_addr + 32'd1;
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0; enable = 1'b1; start_block = 32'd7; sd_card_ready = 1'b1;
        data_in = '0; data_idx = '0; data_rdy = 1'b0;
        #1;
        chk("rst_read_block", 32'(read_block), 32'd0);
        chk("rst_strobe", 32'(sample_strobe), 32'd0);
        chk("rst_addr", block_addr, 32'd0);
        chk("rst_sample", 32'(sample_out), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        cyc(); cyc();
        @(negedge clk); rst_n = 1'b1;
        // enable held high through reset must not start streaming
        repeat (20) cyc();
        chk("no_start_wo_rise", 32'(nreq), 32'd0);

        // start, byte order, flow control
        start_session(32'd100, 1'b1);
        serve_block(0, 1, 0, 0, -1, 0);
        chk("blk1_level", 32'(fifo_level), 32'd256);
        serve_block(0, 0, 0, 3, -1, 0);
        chk("full_level", 32'(fifo_level), 32'd512);
        seen = 0;
        repeat (700) begin
            cyc();
            if (sample_strobe && !seen) begin
                seen = 1;
                chk("first_sample", 32'(sample_out), 32'h1234);
            end
        end
        chk("first_strobe_seen", 32'(seen), 32'd1);
        chk("no_third_req", 32'(nreq), 32'd2);

        // underrun with reader busy; stray bytes outside RECV are ignored
        start_session(32'h55, 1'b0);
        repeat (3 * CLK_DIV + 3) begin
            data_rdy = ($urandom_range(0, 7) == 0);
            data_idx = 12'($urandom_range(0, 511));
            data_in = 8'($urandom);
            cyc();
        end
        data_rdy = 1'b0;
        chk("underrun_sticky", 32'(underrun), 32'd1);
        chk("underrun_no_req", 32'(nreq), 32'd0);

        // mid-block abort and restart at start_block
        start_session(32'd200, 1'b1);
        serve_block(2, 0, 0, 0, 200, 0);
        for (int i = 201; i < 211; i++) send_byte(12'(i), 8'($urandom));
        start_session(32'd200, 1'b1);
        serve_block(1, 0, 0, 0, -1, 0);

        // randomized session with address wrap and a push/pop coincidence
        start_session(32'hFFFF_FFFF, 1'b0);
        repeat ($urandom_range(1400, 1600)) begin
            data_rdy = ($urandom_range(0, 7) == 0);
            data_idx = 12'($urandom_range(0, 511));
            data_in = 8'($urandom);
            cyc();
        end
        data_rdy = 1'b0;
        serve_block(5, 0, 1, 0, -1, 1);
        serve_block(3, 0, 0, 0, -1, 1);
        chk("wrap_reqs", 32'(nreq), 32'd2);
        repeat (50) cyc();

        // asynchronous reset mid-stream
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_addr", block_addr, 32'd0);
        chk("arst_level", 32'(fifo_level), 32'd0);
        chk("arst_sample", 32'(sample_out), 32'd0);
        chk("arst_underrun", 32'(underrun), 32'd0);
        chk("arst_strobe", 32'(sample_strobe), 32'd0);
        chk("arst_read_block", 32'(read_block), 32'd0);
        sd_card_ready = 1'b1; blk_open = 0; nreq = 0;
        cyc(); cyc();
        @(negedge clk); rst_n = 1'b1;
        repeat (30) cyc();
        chk("arst_no_restart", 32'(nreq), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_audio_streamer.md
SD_AUDIO_STREAMER -- requirements
Module: sd_audio_streamer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1134, clock cycles per output sample (about 44.1 kHz at 50 MHz).
REQ-002 SHALL have parameter FIFO_AW, default 9, FIFO address width (512 16-bit samples).
REQ-003 SHALL have one clock and an asynchronous active-low reset, as follows:
- clk  in  1  single system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have the following remaining ports:
- enable  in  1  streaming enable, level.
- start_block  in  32  first SD block address, sampled on enable rise.
- sd_card_ready  in  1  SD reader idle and able to accept a request.
- data_in  in  8  byte from SD reader.
- data_idx  in  12  byte index within block, 0..511.
- data_rdy  in  1  one-cycle strobe, data_in/data_idx valid.
- read_block  out  1  one-cycle block read request.
- block_addr  out  32  block address for the request.
- sample_out  out  16  current PCM sample, signed.
- sample_strobe  out  1  one-cycle pulse per sample period.
- fifo_level  out  FIFO_AW+1  samples held.
- underrun  out  1  sticky, FIFO empty at a sample tick.

Function
REQ-005 SHALL assemble samples little-endian: an even data_idx byte is latched as the low byte; the following odd data_idx byte forms the sample {data_in, low} and pushes it into the FIFO in the same cycle.
REQ-006 SHALL discard an odd byte with no preceding even byte in the current block.
REQ-007 SHALL drop a push when the FIFO is full, leaving level unchanged.
REQ-008 SHALL implement control FSM states IDLE, CHECK, REQ, RECV.
REQ-009 IDLE: when enable rises, SHALL load block_addr = start_block and go to CHECK.
REQ-010 CHECK: when sd_card_ready=1 and free space (2^FIFO_AW − fifo_level) >= 256, SHALL go to REQ.
REQ-011 REQ: SHALL assert read_block for exactly one cycle, then go to RECV.
REQ-012 RECV: on data_rdy with data_idx=511, SHALL increment block_addr by 1 (mod 2^32) and go to CHECK.
REQ-013 SHALL hold block_addr stable from REQ through RECV.
REQ-014 SHALL run a sample divider counting 0..CLK_DIV−1 while enable=1; at the terminal count it SHALL pulse sample_strobe with the registered sample_out, so a pop and the strobe occur in the same cycle.
REQ-015 Tick with FIFO non-empty: sample_out SHALL take the FIFO head and the FIFO SHALL pop.
REQ-016 Tick with FIFO empty: sample_out SHALL be 16'h0000, sample_strobe SHALL still pulse, and underrun SHALL set.
REQ-017 Simultaneous push and pop SHALL leave fifo_level unchanged, with both operations taking effect.
REQ-018 Pop on empty and push on full SHALL never corrupt pointers; pointers SHALL wrap modulo 2^FIFO_AW.
REQ-019 fifo_level SHALL update one cycle after a push or pop.
REQ-020 enable=0 at any state SHALL do all of the following next cycle:
- go to IDLE.
- flush the FIFO (level 0).
- clear the divider, the byte latch and underrun.
- set sample_out to 0.
REQ-021 enable=0 during RECV SHALL ignore the remaining bytes of that block.
REQ-022 data_rdy outside RECV SHALL be ignored.

Reset
REQ-023 On rst_n low, asynchronously and without waiting for a clock edge, SHALL set:
- FSM to IDLE.
- read_block=0, sample_strobe=0.
- block_addr=0, sample_out=0, fifo_level=0, underrun=0.
- divider and FIFO pointers to 0.
REQ-024 After release, SHALL require a fresh enable rising edge to start streaming; enable held high through reset does not count as a rise.

Verification
REQ-025 Start: start_block=100, sd_card_ready=1, enable rises -> one read_block pulse with block_addr=100; after 512 bytes, fifo_level=256; next request uses block_addr=101.
REQ-026 Byte order: bytes idx0=0x34, idx1=0x12 -> first popped sample_out=0x1234 at the first strobe.
REQ-027 Flow control: sd_card_ready=1 constantly, no pops -> exactly 2 requests, fifo_level=512, no third read_block.
REQ-028 Underrun: enable with sd_card_ready=0 -> strobe every CLK_DIV cycles, sample_out=0, underrun=1 after the first strobe.
REQ-029 Simultaneous push and pop on the same cycle -> fifo_level unchanged; data order preserved.
REQ-030 Mid-block abort: deassert enable at data_idx=200 -> next cycle fifo_level=0 and FSM in IDLE; re-enable restarts at start_block.
